fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 17 +
 rtl/fetch_skid_buf.sv | 35 +++
 rtl/fetch_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] BUBBLE           = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer parking a fetched word and its PC while Decode is stalled.
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    // Load takes priority over clear; both never assert together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (clear_i) begin
            instr_q <= '0;
            pc_q    <= '0;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: PC sequencing, memory handshake, Decode register with stall/flush.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCsrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] redir_q, redir_d;

    logic            buf_load;
    logic            buf_clear;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_pc;

    logic            dec_bubble;
    logic            dec_load;
    logic [XLEN-1:0] ld_instr;
    logic [XLEN-1:0] ld_pc;

    logic [XLEN-1:0] pcf_plus4;

    assign pcf_plus4 = pcf_q + PC_STEP;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imem_rdata),
        .pc_i    (pcf_q),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pcf_q   <= RESET_PC;
            instr_q <= BUBBLE;
            pcd_q   <= BUBBLE;
            pcp4_q  <= BUBBLE;
            valid_q <= 1'b0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
        end
    end

    // Flush (PCsrcE) always dominates stall; dropped words only ever become bubbles.
    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        redir_d    = redir_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        dec_bubble = 1'b0;
        dec_load   = 1'b0;
        ld_instr   = imem_rdata;
        ld_pc      = pcf_q;

        unique case (state_q)
            ST_BOOT: begin
                pcf_d   = RESET_PC;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (PCsrcE) begin
                    dec_bubble = 1'b1;
                    if (imem_ready) begin
                        pcf_d = PCTargetE;
                    end else begin
                        redir_d = PCTargetE;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    pcf_d = pcf_plus4;
                    if (!StallD) begin
                        dec_load = 1'b1;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end else if (!StallD) begin
                    dec_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (PCsrcE) begin
                    dec_bubble = 1'b1;
                    buf_clear  = 1'b1;
                    pcf_d      = PCTargetE;
                    state_d    = ST_FETCH;
                end else if (!StallD) begin
                    dec_load  = 1'b1;
                    ld_instr  = buf_instr;
                    ld_pc     = buf_pc;
                    buf_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (PCsrcE) begin
                    dec_bubble = 1'b1;
                    redir_d    = PCTargetE;
                end else if (!StallD) begin
                    dec_bubble = 1'b1;
                end
                if (imem_ready) begin
                    pcf_d   = PCsrcE ? PCTargetE : redir_q;
                    redir_d = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Decode register next-state from the load/bubble decision above.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (dec_bubble) begin
            instr_d = BUBBLE;
            pcd_d   = BUBBLE;
            pcp4_d  = BUBBLE;
            valid_d = 1'b0;
        end else if (dec_load) begin
            instr_d = ld_instr;
            pcd_d   = ld_pc;
            pcp4_d  = ld_pc + PC_STEP;
            valid_d = 1'b1;
        end
    end

    assign imem_req  = reset & ((state_q == ST_FETCH) | (state_q == ST_DRAIN));
    assign imem_addr = pcf_q;
    assign PCF       = pcf_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;

endmodule
